// File: rtl/control_fsm_mw.sv
// Accumulator-CPU control FSM with memory-ready handshake, halt/resume,
// sticky illegal-opcode and memory-timeout flags, and a retired-instruction counter.
module control_fsm_mw #(
  parameter int OPERAND_WIDTH     = 11,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int MEM_WAIT_MAX      = 15,
  parameter int COUNT_WIDTH       = 16,
  localparam int OPC_W            = INSTRUCTION_WIDTH - OPERAND_WIDTH
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic [OPC_W-1:0]       op_code,
  input  logic                   status_Z_in,
  input  logic                   status_N_in,
  input  logic                   mem_ready_in,
  input  logic                   resume_in,
  output logic [1:0]             sel_A_out,
  output logic                   sel_B_out,
  output logic                   alu_op_out,
  output logic                   branch_out,
  output logic                   pc_wr_out,
  output logic                   acc_wr_out,
  output logic                   status_wr_out,
  output logic                   ir_wr_out,
  output logic                   data_memory_wr_out,
  output logic                   acc_reset_out,
  output logic                   pc_reset_out,
  output logic                   status_reset_out,
  output logic                   ir_reset_out,
  output logic                   mem_req_out,
  output logic                   halted_out,
  output logic                   illegal_op_out,
  output logic                   timeout_out,
  output logic [COUNT_WIDTH-1:0] instr_count_out
);

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MWAIT = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_BGT  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_BGE  = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_BLT  = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_BLE  = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(14);

  // Keep the wait counter at least one bit wide when the timeout is disabled.
  localparam int WCW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [WCW-1:0] WMAX = WCW'(MEM_WAIT_MAX);

  logic [2:0]             state_q, state_d;
  logic [WCW-1:0]         wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   ill_q, ill_d;
  logic                   to_q, to_d;
  logic                   cause_q, cause_d;   // 0: HLT instruction, 1: timeout

  logic [1:0] d_sel_a;
  logic       d_sel_b, d_alu, d_acc, d_st, d_dm, d_br, d_mem, d_hlt, d_ill;
  logic       retire, tmo_hit;

  always_comb begin
    d_sel_a = 2'b00;
    d_sel_b = 1'b0;
    d_alu   = 1'b0;
    d_acc   = 1'b0;
    d_st    = 1'b0;
    d_dm    = 1'b0;
    d_br    = 1'b0;
    d_mem   = 1'b0;
    d_hlt   = 1'b0;
    d_ill   = 1'b0;
    case (op_code)
      OP_HLT:  d_hlt = 1'b1;
      OP_STO:  begin d_mem = 1'b1; d_dm = 1'b1; end
      OP_LD:   begin d_mem = 1'b1; d_acc = 1'b1; end
      OP_LDI:  begin d_sel_a = 2'b01; d_acc = 1'b1; end
      OP_ADD:  begin d_sel_a = 2'b10; d_acc = 1'b1; d_st = 1'b1; end
      OP_ADDI: begin d_sel_a = 2'b10; d_sel_b = 1'b1; d_acc = 1'b1; d_st = 1'b1; end
      OP_SUB:  begin d_sel_a = 2'b10; d_alu = 1'b1; d_acc = 1'b1; d_st = 1'b1; end
      OP_SUBI: begin d_sel_a = 2'b10; d_sel_b = 1'b1; d_alu = 1'b1; d_acc = 1'b1; d_st = 1'b1; end
      OP_BEQ:  d_br = status_Z_in;
      OP_BNE:  d_br = !status_Z_in;
      OP_BGT:  d_br = !status_Z_in && !status_N_in;
      OP_BGE:  d_br = !status_N_in;
      OP_BLT:  d_br = status_N_in;
      OP_BLE:  d_br = status_Z_in || status_N_in;
      OP_JMP:  d_br = 1'b1;
      default: d_ill = 1'b1;
    endcase
  end

  assign tmo_hit = (MEM_WAIT_MAX > 0) && (wait_q == WMAX) && !mem_ready_in;

  always_comb begin
    sel_A_out          = 2'b00;
    sel_B_out          = 1'b0;
    alu_op_out         = 1'b0;
    branch_out         = 1'b0;
    pc_wr_out          = 1'b0;
    acc_wr_out         = 1'b0;
    status_wr_out      = 1'b0;
    ir_wr_out          = 1'b0;
    data_memory_wr_out = 1'b0;
    acc_reset_out      = 1'b0;
    pc_reset_out       = 1'b0;
    status_reset_out   = 1'b0;
    ir_reset_out       = 1'b0;
    mem_req_out        = 1'b0;
    halted_out         = 1'b0;
    state_d            = state_q;
    cause_d            = cause_q;
    retire             = 1'b0;
    ill_d              = ill_q;
    to_d               = to_q;
    case (state_q)
      S_RESET: begin
        acc_reset_out    = 1'b1;
        pc_reset_out     = 1'b1;
        status_reset_out = 1'b1;
        ir_reset_out     = 1'b1;
        state_d          = S_FETCH;
      end
      S_FETCH: begin
        mem_req_out = 1'b1;
        if (mem_ready_in) begin
          ir_wr_out = 1'b1;
          state_d   = S_EXEC;
        end else if (tmo_hit) begin
          to_d    = 1'b1;
          cause_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        sel_A_out  = d_sel_a;
        sel_B_out  = d_sel_b;
        alu_op_out = d_alu;
        if (d_hlt) begin
          retire  = 1'b1;
          cause_d = 1'b0;
          state_d = S_HALT;
        end else if (d_mem) begin
          mem_req_out = 1'b1;
          if (mem_ready_in) begin
            pc_wr_out          = 1'b1;
            acc_wr_out         = d_acc;
            data_memory_wr_out = d_dm;
            retire             = 1'b1;
            state_d            = S_FETCH;
          end else begin
            state_d = S_MWAIT;
          end
        end else begin
          pc_wr_out     = 1'b1;
          acc_wr_out    = d_acc;
          status_wr_out = d_st;
          branch_out    = d_br;
          ill_d         = ill_q | d_ill;
          retire        = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_MWAIT: begin
        mem_req_out = 1'b1;
        if (mem_ready_in) begin
          pc_wr_out          = 1'b1;
          acc_wr_out         = d_acc;
          data_memory_wr_out = d_dm;
          retire             = 1'b1;
          state_d            = S_FETCH;
        end else if (tmo_hit) begin
          to_d    = 1'b1;
          cause_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        halted_out = 1'b1;
        if (resume_in) begin
          pc_wr_out = !cause_q;   // step past HLT; a timed-out access is retried instead
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (mem_ready_in || (state_d != state_q))
      wait_d = '0;
    else if (state_q == S_FETCH || state_q == S_MWAIT)
      wait_d = wait_q + WCW'(1);
  end

  assign cnt_d = retire ? cnt_q + COUNT_WIDTH'(1) : cnt_q;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= S_RESET;
      wait_q  <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
      cause_q <= cause_d;
    end
  end

  assign illegal_op_out  = ill_q;
  assign timeout_out     = to_q;
  assign instr_count_out = cnt_q;

endmodule

// File: tb/tb_control_fsm_mw.sv
// Directed-vector bench: the driver queues the hand-computed expected control
// vector for each cycle, and a monitor compares it against the DUT mid-cycle.
module tb_control_fsm_mw;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, z, n, rdy, res;
  logic [4:0]  op;
  logic [1:0]  sel_a;
  logic        sel_b, alu, br, pc_wr, acc_wr, st_wr, ir_wr, dm_wr;
  logic        acc_rst, pc_rst, st_rst, ir_rst, req, halted, ill, tmo;
  logic [CW-1:0] cnt;

  control_fsm_mw #(.OPERAND_WIDTH(11), .INSTRUCTION_WIDTH(16), .MEM_WAIT_MAX(4),
                   .COUNT_WIDTH(CW)) dut (
    .clock_in(clk), .reset_in(rst_n), .op_code(op), .status_Z_in(z), .status_N_in(n),
    .mem_ready_in(rdy), .resume_in(res), .sel_A_out(sel_a), .sel_B_out(sel_b),
    .alu_op_out(alu), .branch_out(br), .pc_wr_out(pc_wr), .acc_wr_out(acc_wr),
    .status_wr_out(st_wr), .ir_wr_out(ir_wr), .data_memory_wr_out(dm_wr),
    .acc_reset_out(acc_rst), .pc_reset_out(pc_rst), .status_reset_out(st_rst),
    .ir_reset_out(ir_rst), .mem_req_out(req), .halted_out(halted),
    .illegal_op_out(ill), .timeout_out(tmo), .instr_count_out(cnt));

  localparam logic [17:0] SA_IMM = 18'h1 << 16;
  localparam logic [17:0] SA_ALU = 18'h1 << 17;
  localparam logic [17:0] SB     = 18'h1 << 15;
  localparam logic [17:0] ALU    = 18'h1 << 14;
  localparam logic [17:0] BR     = 18'h1 << 13;
  localparam logic [17:0] PC     = 18'h1 << 12;
  localparam logic [17:0] ACC    = 18'h1 << 11;
  localparam logic [17:0] ST     = 18'h1 << 10;
  localparam logic [17:0] IR     = 18'h1 << 9;
  localparam logic [17:0] DM     = 18'h1 << 8;
  localparam logic [17:0] RSTS   = 18'hF << 4;
  localparam logic [17:0] REQ    = 18'h1 << 3;
  localparam logic [17:0] HLTD   = 18'h1 << 2;
  localparam logic [17:0] ILL    = 18'h1 << 1;
  localparam logic [17:0] TO     = 18'h1;
  localparam logic [17:0] NONE   = 18'h0;

  localparam logic [4:0] LD = 5'b00010, STO = 5'b00001, LDI = 5'b00011, ADD = 5'b00100;
  localparam logic [4:0] SUBI = 5'b00111, BEQ = 5'b01000, BLE = 5'b01101, HLT = 5'b00000;
  localparam logic [4:0] BAD = 5'b10110;

  typedef struct {
    int            step;
    logic [17:0]   ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   step = 0;

  wire [17:0] act = {sel_a, sel_b, alu, br, pc_wr, acc_wr, st_wr, ir_wr, dm_wr,
                     acc_rst, pc_rst, st_rst, ir_rst, req, halted, ill, tmo};

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (act !== e.ctl) begin
          bad++;
          $display("FAIL ctl step %0d got %h want %h", e.step, act, e.ctl);
        end
        total++;
        if (cnt !== e.cnt) begin
          bad++;
          $display("FAIL count step %0d got %0d want %0d", e.step, cnt, e.cnt);
        end
      end
    end
  end

  // One clock cycle: drive inputs just after the rising edge, queue the expectation.
  task automatic cyc(input logic r, input logic [4:0] o, input logic zz, input logic nn,
                     input logic rd, input logic rs, input logic [17:0] ec,
                     input logic [CW-1:0] en);
    exp_t e;
    rst_n = r; op = o; z = zz; n = nn; rdy = rd; res = rs;
    e.step = step; e.ctl = ec; e.cnt = en;
    q.push_back(e);
    step++;
    @(posedge clk); #1;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; op = LDI; z = 1'b0; n = 1'b0; rdy = 1'b1; res = 1'b0;
    @(posedge clk); #1;
    // reset, then LDI
    cyc(0, LDI, 0, 0, 1, 0, RSTS, 0);
    cyc(1, LDI, 0, 0, 1, 0, RSTS, 0);
    cyc(1, LDI, 0, 0, 1, 0, REQ | IR, 0);
    cyc(1, LDI, 0, 0, 1, 0, SA_IMM | ACC | PC, 0);
    // ADD, SUBI, BLE with Z=0 N=1
    cyc(1, ADD, 0, 1, 1, 0, REQ | IR, 1);
    cyc(1, ADD, 0, 1, 1, 0, SA_ALU | ACC | ST | PC, 1);
    cyc(1, SUBI, 0, 1, 1, 0, REQ | IR, 2);
    cyc(1, SUBI, 0, 1, 1, 0, SA_ALU | SB | ALU | ACC | ST | PC, 2);
    cyc(1, BLE, 0, 1, 1, 0, REQ | IR, 3);
    cyc(1, BLE, 0, 1, 1, 0, BR | PC, 3);
    // again with Z=0 N=0: branch not taken
    cyc(1, ADD, 0, 0, 1, 0, REQ | IR, 4);
    cyc(1, ADD, 0, 0, 1, 0, SA_ALU | ACC | ST | PC, 4);
    cyc(1, BLE, 0, 0, 1, 0, REQ | IR, 5);
    cyc(1, BLE, 0, 0, 1, 0, PC, 5);
    cyc(1, BEQ, 1, 0, 1, 0, REQ | IR, 6);
    cyc(1, BEQ, 1, 0, 1, 0, BR | PC, 6);
    // LD with ready low for three cycles
    cyc(1, LD, 0, 0, 1, 0, REQ | IR, 7);
    cyc(1, LD, 0, 0, 0, 0, REQ, 7);
    cyc(1, LD, 0, 0, 0, 0, REQ, 7);
    cyc(1, LD, 0, 0, 0, 0, REQ, 7);
    cyc(1, LD, 0, 0, 1, 0, REQ | ACC | PC, 7);
    // STO completing immediately
    cyc(1, STO, 0, 0, 1, 0, REQ | IR, 8);
    cyc(1, STO, 0, 0, 1, 0, REQ | DM | PC, 8);
    // HLT, five held cycles, resume steps the PC
    cyc(1, HLT, 0, 0, 1, 0, REQ | IR, 9);
    cyc(1, HLT, 0, 0, 1, 0, NONE, 9);
    for (int i = 0; i < 5; i++) cyc(1, HLT, 0, 0, 1, 0, HLTD, 10);
    cyc(1, HLT, 0, 0, 1, 1, HLTD | PC, 10);
    // resume outside HALT is ignored
    cyc(1, LDI, 0, 0, 1, 1, REQ | IR, 10);
    cyc(1, LDI, 0, 0, 1, 1, SA_IMM | ACC | PC, 10);
    // ready on the fifth fetch cycle: no timeout
    for (int i = 0; i < 4; i++) cyc(1, LDI, 0, 0, 0, 0, REQ, 11);
    cyc(1, LDI, 0, 0, 1, 0, REQ | IR, 11);
    cyc(1, LDI, 0, 0, 1, 0, SA_IMM | ACC | PC, 11);
    // fetch never ready: timeout on the fifth cycle, resume without PC write
    for (int i = 0; i < 5; i++) cyc(1, LDI, 0, 0, 0, 0, REQ, 12);
    cyc(1, LDI, 0, 0, 0, 0, HLTD | TO, 12);
    cyc(1, LDI, 0, 0, 0, 1, HLTD | TO, 12);
    // illegal opcode
    cyc(1, BAD, 0, 0, 1, 0, REQ | IR | TO, 12);
    cyc(1, BAD, 0, 0, 1, 0, PC | TO, 12);
    // reset in the middle of a memory wait
    cyc(1, LD, 0, 0, 1, 0, REQ | IR | ILL | TO, 13);
    cyc(1, LD, 0, 0, 0, 0, REQ | ILL | TO, 13);
    cyc(1, LD, 0, 0, 0, 0, REQ | ILL | TO, 13);
    cyc(0, LD, 0, 0, 1, 0, RSTS, 0);
    cyc(1, LDI, 0, 0, 1, 0, RSTS, 0);
    cyc(1, LDI, 0, 0, 1, 0, REQ | IR, 0);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
